// File: rtl/hazard3_clint.sv
// hazard3_clint: APB-attached core-local interruptor.
// Provides the mtime timebase with a tick prescaler, per-hart mtimecmp/timer
// interrupts and per-hart software interrupts (MSIP).
// Optional feature: define HAZARD3_CLINT_SNAPSHOT_EN to make an MTIME read
// capture mtime[63:32] into a shadow register that MTIMEH reads then return.
module hazard3_clint #(
  parameter int N_HARTS     = 2,
  parameter bit TICK_IS_NRZ = 1'b0,
  parameter int PRESCALE_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq
);

  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_PRESCALE = 16'h0004;
  localparam logic [15:0] ADDR_MTIME    = 16'h0008;
  localparam logic [15:0] ADDR_MTIMEH   = 16'h000c;

  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp [N_HARTS];
  logic [31:0]           mtimeh_rdata;

  logic                  addr_hit;
  logic                  sel_ctrl, sel_prescale, sel_mtime, sel_mtimeh;
  logic [N_HARTS-1:0]    sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic [31:0]           rdata;

  logic                  bus_wr, bus_rd;
  logic                  tick_event, tick_now, pcnt_wrap;

  assign bus_wr  = psel & penable & pwrite;
  assign bus_rd  = psel & penable & ~pwrite;
  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~addr_hit;
  assign prdata  = rdata;

  // Address decode and combinational read mux; unmapped addresses read as zero.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    addr_hit     = 1'b0;
    rdata        = '0;
    sel_ctrl     = (paddr == ADDR_CTRL);
    sel_prescale = (paddr == ADDR_PRESCALE);
    sel_mtime    = (paddr == ADDR_MTIME);
    sel_mtimeh   = (paddr == ADDR_MTIMEH);
    sel_msip     = '0;
    sel_cmp_lo   = '0;
    sel_cmp_hi   = '0;
    if (sel_ctrl)     rdata = {31'b0, en};
    if (sel_prescale) rdata = 32'(prescale);
    if (sel_mtime)    rdata = mtime[31:0];
    if (sel_mtimeh)   rdata = mtimeh_rdata;
    for (int h = 0; h < N_HARTS; h++) begin
      sel_msip[h]   = (paddr == 16'(32'h1000 + 4 * h));
      sel_cmp_lo[h] = (paddr == 16'(32'h4000 + 8 * h));
      sel_cmp_hi[h] = (paddr == 16'(32'h4004 + 8 * h));
      if (sel_msip[h])   rdata = {31'b0, soft_irq[h]};
      if (sel_cmp_lo[h]) rdata = mtimecmp[h][31:0];
      if (sel_cmp_hi[h]) rdata = mtimecmp[h][63:32];
    end
    addr_hit = sel_ctrl | sel_prescale | sel_mtime | sel_mtimeh |
               (|sel_msip) | (|sel_cmp_lo) | (|sel_cmp_hi);
  end

  // Tick event source: edge-detected synchronised NRZ toggle, or a plain level.
  generate
    if (TICK_IS_NRZ) begin : g_tick_nrz
      logic [2:0] tick_sync;
      // Two synchroniser flops plus one history flop for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_sync <= '0;
        else        tick_sync <= {tick_sync[1:0], tick};
      end
      assign tick_event = tick_sync[2] ^ tick_sync[1];
    end else begin : g_tick_level
      assign tick_event = tick;
    end
  endgenerate

  assign tick_now  = tick_event & en & ~dbg_halt;
  assign pcnt_wrap = (pcnt == prescale);

  // Control registers, MSIP bits and per-hart compare values.
  // NOTE: mtimecmp is a small flop array, not RAM, so it takes a real async reset to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b1;
      prescale <= '0;
      soft_irq <= '0;
      for (int h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (bus_wr && sel_ctrl)     en       <= pwdata[0];
      if (bus_wr && sel_prescale) prescale <= pwdata[PRESCALE_W-1:0];
      for (int h = 0; h < N_HARTS; h++) begin
        if (bus_wr && sel_msip[h])   soft_irq[h]        <= pwdata[0];
        if (bus_wr && sel_cmp_lo[h]) mtimecmp[h][31:0]  <= pwdata;
        if (bus_wr && sel_cmp_hi[h]) mtimecmp[h][63:32] <= pwdata;
      end
    end
  end

  // Prescaler counter: cleared by a PRESCALE write, otherwise advances on tick_now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pcnt <= '0;
    else if (bus_wr && sel_prescale) pcnt <= '0;
    else if (tick_now)          pcnt <= pcnt_wrap ? '0 : pcnt + 1'b1;
  end

  // mtime: a bus write to either half wins over that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     mtime        <= '0;
    else if (bus_wr && sel_mtime)   mtime[31:0]  <= pwdata;
    else if (bus_wr && sel_mtimeh)  mtime[63:32] <= pwdata;
    else if (tick_now && pcnt_wrap) mtime        <= mtime + 64'd1;
  end

  // Registered timer interrupt comparison, one cycle behind mtime/mtimecmp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_irq <= '0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) timer_irq[h] <= (mtime >= mtimecmp[h]);
    end
  end

`ifdef HAZARD3_CLINT_SNAPSHOT_EN
  logic [31:0] mtimeh_shadow;
  // Reading MTIME latches the upper half so a following MTIMEH read is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   mtimeh_shadow <= '0;
    else if (bus_rd && sel_mtime) mtimeh_shadow <= mtime[63:32];
  end
  assign mtimeh_rdata = mtimeh_shadow;
`else
  assign mtimeh_rdata = mtime[63:32];
`endif

endmodule
